mul31_rr_scheduler: RTL

//  Shares one hibrid_mul31 (31x31 -> 62-bit) multiplier among NREQ requesters.
//  - Round-robin arbitration; at most one product issued per clock.
//  - Tracks in-flight operations through the multiplier pipeline and returns each product tagged with its requester id.
//  - Sits between the NTT/coefficient-wise units and the shared multiplier, ahead of modular reduction.

---
 rtl/mul31_pkg.sv | 16 +
 rtl/hibrid_mul31.sv | 29 ++
 rtl/rr_pick.sv | 30 +++
 rtl/mul31_rr_scheduler.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mul31_pkg.sv
// Shared widths and helpers for the mul31 datapath.
// Single source of truth for the multiplier pipeline depth.
package mul31_pkg;

  localparam int MUL31_W   = 31;
  localparam int MUL31_PW  = 62;
  localparam int MUL31_LAT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hibrid_mul31.sv
// 31x31 -> 62-bit multiplier with LAT register stages.
// Inputs are expected to come from registers upstream.
module hibrid_mul31
  import mul31_pkg::*;
#(
  parameter int LAT = MUL31_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MUL31_W-1:0]  a,
  input  logic [MUL31_W-1:0]  b,
  output logic [MUL31_PW-1:0] p
);

  logic [MUL31_PW-1:0] pipe [LAT];

  // Product enters stage 0, then shifts through the remaining stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= MUL31_PW'(a) * MUL31_PW'(b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[LAT-1];

endmodule

// File: rtl/rr_pick.sv
// Rotating priority search: first eligible index at or after ptr.
// Pure combinational; the pointer register lives in the caller.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk offsets 0..N-1 from ptr; first hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && elig[j] && (j == (int'(ptr) + k) % N)) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mul31_rr_scheduler.sv
// Round-robin front end sharing one hibrid_mul31 among NREQ users.
// Results come back tagged with the requester id, in issue order.
module mul31_rr_scheduler
  import mul31_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TAGW    = clog2(NREQ),
  parameter int MUL_LAT = MUL31_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*MUL31_W-1:0] req_a,
  input  logic [NREQ*MUL31_W-1:0] req_b,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_mask,
  output logic                    res_valid,
  output logic [TAGW-1:0]         res_tag,
  output logic [MUL31_PW-1:0]     res_c,
  output logic                    busy,
  output logic [31:0]             issue_cnt
);

  localparam int LAT = MUL_LAT + 2;
  localparam int SRD = LAT - 1;

  logic [TAGW-1:0]     ptr;
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     gnt;
  logic [TAGW-1:0]     gidx;
  logic                fire;
  logic [MUL31_W-1:0]  sel_a;
  logic [MUL31_W-1:0]  sel_b;
  logic [MUL31_W-1:0]  op_a;
  logic [MUL31_W-1:0]  op_b;
  logic [MUL31_PW-1:0] mul_p;
  logic [SRD-1:0]      vsr;
  logic [TAGW-1:0]     tsr [SRD];
  logic [TAGW-1:0]     ptr_nxt;

  assign elig = req_valid & req_mask;

  rr_pick #(
    .N  (NREQ),
    .IW (TAGW)
  ) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (fire)
  );

  // No grants are shown while reset is held
  assign req_ready = gnt & {NREQ{rst_n}};

  assign ptr_nxt = (gidx == TAGW'(NREQ - 1)) ? '0 : gidx + TAGW'(1);

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*MUL31_W +: MUL31_W];
        sel_b = req_b[i*MUL31_W +: MUL31_W];
      end
    end
  end

  // Pointer, operand regs and issue counter advance only on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      issue_cnt <= '0;
    end else if (fire) begin
      ptr       <= ptr_nxt;
      op_a      <= sel_a;
      op_b      <= sel_b;
      issue_cnt <= issue_cnt + 32'd1;
    end
  end

  hibrid_mul31 #(
    .LAT (MUL_LAT)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (op_a),
    .b     (op_b),
    .p     (mul_p)
  );

  // Valid/tag shift register tracks ops alongside the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr <= '0;
      for (int s = 0; s < SRD; s++) tsr[s] <= '0;
    end else begin
      vsr[0] <= fire;
      tsr[0] <= gidx;
      for (int s = 1; s < SRD; s++) begin
        vsr[s] <= vsr[s-1];
        tsr[s] <= tsr[s-1];
      end
    end
  end

  // Result registers capture only when a tracked op arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_c     <= '0;
    end else begin
      res_valid <= vsr[SRD-1];
      if (vsr[SRD-1]) begin
        res_tag <= tsr[SRD-1];
        res_c   <= mul_p;
      end
    end
  end

  assign busy = (|vsr) | res_valid;

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  a_ready_valid: assert property (
    @(posedge clk) disable iff (!rst_n) ((req_ready & ~req_valid) == '0));

  a_res_accept: assert property (
    @(posedge clk) disable iff (!rst_n) res_valid |-> $past(vsr[SRD-1]));

endmodule
